spi_adc_slave: RTL and testbench

SPI responder that emulates a serial ADC on the far end of the team's SPI read master. It runs on the system clock, oversamples `sclk` and `cs_n`, and shifts out a 16-bit frame on `sdata`: leading zeros, an 8-bit sample MSB-first, then trailing zeros. The sample value is loaded from the fabric through a valid/ready port. It serves as a synthesizable peer for master bring-up and as a loopback target on boards without a real converter.

---
 rtl/spi_pkg.sv | 14 +
 rtl/sync_edge.sv | 35 +++
 rtl/spi_adc_slave.sv | 122 ++++++++++++
 tb/tb_spi_adc_slave.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI framing constants and the responder state encoding.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TAIL  = 2'd2
   } state_t;

   localparam int unsigned SPI_FRAME_LEN  = 16;
   localparam int unsigned SPI_LEAD_ZEROS = 3;
   localparam int unsigned SPI_DATA_W     = 8;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with edge detection for an asynchronous input.
module sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Synchronizer chain plus one flop holding the previous synchronized level.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {SYNC_STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            chain[i] <= chain[i-1];
         end
         prev <= chain[SYNC_STAGES-1];
      end
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_adc_slave.sv
// SPI responder emulating a serial ADC: leading zeros, sample MSB-first, trailing zeros.
module spi_adc_slave
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = SPI_DATA_W,
   parameter int unsigned LEAD_ZEROS  = SPI_LEAD_ZEROS,
   parameter int unsigned FRAME_LEN   = SPI_FRAME_LEN,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sdata,
   output logic              busy,
   output logic              frame_done,
   output logic              aborted
);

   localparam int unsigned KW = $clog2(FRAME_LEN + 1);

   state_t              state;
   logic [KW-1:0]       k;
   logic [KW-1:0]       k_next;
   logic [DATA_W-1:0]   hold;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   load_val;
   logic                cs_level, cs_rise, cs_fall;
   logic                sclk_level, sclk_rise, sclk_fall;
   logic                unused_sync;

   // Bit value on the wire for frame position idx given sample val.
   function automatic logic frame_bit(input int unsigned idx, input logic [DATA_W-1:0] val);
      logic [DATA_W-1:0] sh;
      sh = val << (idx - LEAD_ZEROS);
      if (idx < LEAD_ZEROS || idx >= LEAD_ZEROS + DATA_W) return 1'b0;
      return sh[DATA_W-1];
   endfunction

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
      .clk   (clk),
      .rst   (rst),
      .d     (sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   assign unused_sync = ^{cs_level, sclk_level, sclk_rise};
   assign din_ready   = (state == IDLE);
   assign k_next      = k + KW'(1);
   // A sample offered on the cs_n-fall cycle bypasses hold straight into the frame.
   assign load_val    = din_valid ? din : hold;

   // Frame sequencer: holding register, shift position and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         hold       <= '0;
         shreg      <= '0;
         sdata      <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         aborted    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         aborted    <= 1'b0;
         if (din_valid && din_ready) hold <= din;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
                  k     <= '0;
                  shreg <= load_val;
                  sdata <= frame_bit(0, load_val);
               end
            end
            SHIFT: begin
               // cs_n rise has priority over a coincident sclk fall.
               if (cs_rise) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
                  sdata   <= 1'b1;
               end else if (sclk_fall) begin
                  k <= k_next;
                  if (k_next == KW'(FRAME_LEN)) begin
                     state      <= TAIL;
                     frame_done <= 1'b1;
                     sdata      <= 1'b0;
                  end else begin
                     sdata <= frame_bit(32'(k_next), shreg);
                  end
               end
            end
            TAIL: begin
               if (cs_rise) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  sdata <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Bench for spi_adc_slave acting as the SPI master, checking frames bit by bit.
module tb_spi_adc_slave;

   localparam int LZ = 3;
   localparam int DW = 8;
   localparam int FL = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk = 1'b1;
   logic       cs_n = 1'b1;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       din_ready, sdata, busy, frame_done, aborted;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   int n_abort = 0;
   int n_both = 0;
   logic [7:0] model_hold = 8'h00;

   typedef struct {
      bit         do_load;
      logic [7:0] val;
      int         falls;
      int         half;
      logic [15:0] pat;
   } vec_t;

   vec_t tbl[5];

   spi_adc_slave dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .cs_n       (cs_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .sdata      (sdata),
      .busy       (busy),
      .frame_done (frame_done),
      .aborted    (aborted)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_done === 1'b1) n_done++;
      if (aborted === 1'b1) n_abort++;
      if (frame_done === 1'b1 && aborted === 1'b1) n_both++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected wire pattern, bit i of the frame at position FL-1-i.
   function automatic logic [15:0] pat_of(input logic [7:0] v);
      return 16'(v) << (FL - LZ - DW);
   endfunction

   task automatic load(input logic [7:0] v);
      chk("ready_idle", 32'(din_ready), 32'd1);
      din = v;
      din_valid = 1'b1;
      tick(1);
      din_valid = 1'b0;
      model_hold = v;
      tick(2);
   endtask

   task automatic run_frame(input string tag, input int falls, input int half, input logic [15:0] pat,
                            input bit offer, input bit sc, input logic [7:0] sc_val);
      int d0, a0;
      d0 = n_done;
      a0 = n_abort;
      cs_n = 1'b0;
      if (sc) begin
         tick(2);
         din = sc_val;
         din_valid = 1'b1;
         chk({tag, " ready_at_fall"}, 32'(din_ready), 32'd1);
         tick(1);
         din_valid = 1'b0;
         model_hold = sc_val;
         tick(half - 3);
      end else begin
         tick(half);
      end
      chk({tag, " busy_start"}, 32'(busy), 32'd1);
      for (int i = 0; i < falls; i++) begin
         chk($sformatf("%s bit%0d", tag, i), 32'(sdata), 32'(pat[FL-1-i]));
         if (offer && i == 2) begin
            din = 8'h3C;
            din_valid = 1'b1;
         end
         sclk = 1'b1;
         tick(half);
         if (offer && i == 2) begin
            chk({tag, " ready_busy"}, 32'(din_ready), 32'd0);
            din_valid = 1'b0;
         end
         sclk = 1'b0;
         tick(half);
      end
      if (falls >= FL) begin
         chk({tag, " tail_busy"}, 32'(busy), 32'd1);
         chk({tag, " tail_sdata"}, 32'(sdata), 32'd0);
         chk({tag, " done_cnt"}, 32'(n_done - d0), 32'd1);
         cs_n = 1'b1;
         tick(half);
         chk({tag, " idle_busy"}, 32'(busy), 32'd0);
         chk({tag, " idle_sdata"}, 32'(sdata), 32'd1);
         chk({tag, " idle_ready"}, 32'(din_ready), 32'd1);
         chk({tag, " done_once"}, 32'(n_done - d0), 32'd1);
         chk({tag, " no_abort"}, 32'(n_abort - a0), 32'd0);
      end else begin
         cs_n = 1'b1;
         tick(half);
         chk({tag, " abort_cnt"}, 32'(n_abort - a0), 32'd1);
         chk({tag, " abort_nodone"}, 32'(n_done - d0), 32'd0);
         chk({tag, " abort_sdata"}, 32'(sdata), 32'd1);
         chk({tag, " abort_busy"}, 32'(busy), 32'd0);
      end
      sclk = 1'b1;
      tick(half);
   endtask

   initial begin
      int d0, a0, half, falls;
      logic [7:0] v;

      tbl[0] = '{1'b1, 8'hA5, 16, 6,  16'h14A0};
      tbl[1] = '{1'b0, 8'h00, 6,  6,  16'h14A0};
      tbl[2] = '{1'b0, 8'h00, 16, 6,  16'h14A0};
      tbl[3] = '{1'b1, 8'h00, 16, 20, 16'h0000};
      tbl[4] = '{1'b1, 8'h81, 16, 20, 16'h1020};

      // Reset state.
      tick(3);
      chk("rst_sdata", 32'(sdata), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(din_ready), 32'd1);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_abort", 32'(aborted), 32'd0);
      rst = 1'b0;
      tick(5);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // Table-driven frames: full, abort, resend, back-to-back.
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].do_load) load(tbl[i].val);
         run_frame($sformatf("tbl%0d", i), tbl[i].falls, tbl[i].half, tbl[i].pat, 1'b0, 1'b0, 8'h00);
      end

      // din offered while busy is refused; next frame sends it after acceptance.
      run_frame("reject", 16, 6, 16'h1020, 1'b1, 1'b0, 8'h00);
      load(8'h3C);
      run_frame("after_reject", 16, 6, 16'h0780, 1'b0, 1'b0, 8'h00);

      // Accept on the same cycle the cs_n fall is detected.
      run_frame("samecyc", 16, 6, 16'h1FE0, 1'b0, 1'b1, 8'hFF);
      run_frame("samecyc_hold", 16, 7, pat_of(model_hold), 1'b0, 1'b0, 8'h00);

      // Reset mid-frame, with cs_n held low across reset release.
      d0 = n_done;
      a0 = n_abort;
      cs_n = 1'b0;
      tick(6);
      for (int i = 0; i < 9; i++) begin
         sclk = 1'b1;
         tick(6);
         sclk = 1'b0;
         tick(6);
      end
      rst = 1'b1;
      tick(1);
      chk("mid_rst_sdata", 32'(sdata), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ready", 32'(din_ready), 32'd1);
      tick(1);
      rst = 1'b0;
      model_hold = 8'h00;
      tick(12);
      chk("cs_low_no_start", 32'(busy), 32'd0);
      chk("cs_low_sdata", 32'(sdata), 32'd1);
      chk("rst_no_done", 32'(n_done - d0), 32'd0);
      chk("rst_no_abort", 32'(n_abort - a0), 32'd0);
      sclk = 1'b1;
      cs_n = 1'b1;
      tick(8);
      run_frame("post_rst", 16, 6, pat_of(model_hold), 1'b0, 1'b0, 8'h00);
      load(8'h5A);
      run_frame("post_rst_ld", 16, 6, 16'h0B40, 1'b0, 1'b0, 8'h00);

      // Randomized frames against the pattern model.
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            v = 8'($urandom);
            load(v);
         end
         half = int'($urandom_range(5, 12));
         falls = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : FL;
         run_frame($sformatf("rnd%0d", r), falls, half, pat_of(model_hold), 1'b0, 1'b0, 8'h00);
      end

      chk("done_abort_overlap", 32'(n_both), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
